// File: rtl/mtm_alu_packet_tx.sv
// mtm_alu_packet_tx: serial packet encoder that feeds mtm_Alu_deserializer.
// It captures one ALU command (A, B, OP), computes its 4-bit CRC and sends
// nine 11-bit frames on sin. It can optionally inject a CRC or framing error.
module mtm_alu_packet_tx #(
  parameter int FRAME_GAP = 0,
  parameter int PKT_GAP   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  input  logic [1:0]  err_mode,
  output logic        sin,
  output logic        busy,
  output logic        done,
  output logic [3:0]  crc
);

  localparam int GAP_MAX = (FRAME_GAP > PKT_GAP) ? FRAME_GAP : PKT_GAP;
  localparam int GW      = (GAP_MAX > 1) ? $clog2(GAP_MAX + 1) : 1;
  localparam logic [GW-1:0] FGAP_LAST = GW'(FRAME_GAP - 1);
  localparam logic [GW-1:0] PGAP_LAST = GW'(PKT_GAP - 1);

  typedef enum logic [1:0] {IDLE, FRAME, GAP, TAIL} state_t;

  state_t        state;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [2:0]    op_q;
  logic [1:0]    mode_q;
  logic [3:0]    bit_cnt;
  logic [3:0]    frame_cnt;
  logic [GW-1:0] gap_cnt;

  logic [7:0]    payload;
  logic          marker;
  logic [3:0]    next_idx;
  logic          next_bit;

  // The CRC is x^4+x+1 with a zero seed. It runs MSB-first over {A, B, 1, OP}.
  function automatic logic [3:0] crc4(input logic [67:0] data);
    logic [3:0] c;
    logic       fb;
    c = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ data[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  // Choose the level of the next bit of the current frame.
  // The stop bit is the default level, so it needs no case item of its own.
  always_comb begin
    payload = 8'h00;
    case (frame_cnt)
      4'd0:    payload = a_q[31:24];
      4'd1:    payload = a_q[23:16];
      4'd2:    payload = a_q[15:8];
      4'd3:    payload = a_q[7:0];
      4'd4:    payload = b_q[31:24];
      4'd5:    payload = b_q[23:16];
      4'd6:    payload = b_q[15:8];
      4'd7:    payload = b_q[7:0];
      default: payload = {1'b0, op_q, crc ^ {3'b000, (mode_q == 2'b01)}};
    endcase
    marker   = (frame_cnt == 4'd8) || ((frame_cnt == 4'd0) && (mode_q == 2'b10));
    next_idx = bit_cnt + 4'd1;
    next_bit = 1'b1;
    case (next_idx)
      4'd1:    next_bit = marker;
      4'd2:    next_bit = payload[7];
      4'd3:    next_bit = payload[6];
      4'd4:    next_bit = payload[5];
      4'd5:    next_bit = payload[4];
      4'd6:    next_bit = payload[3];
      4'd7:    next_bit = payload[2];
      4'd8:    next_bit = payload[1];
      4'd9:    next_bit = payload[0];
      default: next_bit = 1'b1;
    endcase
  end

  // This FSM sequences frames, gaps and the tail. All outputs are registered,
  // so each output shows the bit that the state just entered calls for.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      sin       <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      crc       <= 4'b0000;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      mode_q    <= '0;
      bit_cnt   <= '0;
      frame_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q       <= a;
            b_q       <= b;
            op_q      <= op;
            mode_q    <= err_mode;
            crc       <= crc4({a, b, 1'b1, op});
            bit_cnt   <= '0;
            frame_cnt <= '0;
            sin       <= 1'b0;
            busy      <= 1'b1;
            state     <= FRAME;
          end else begin
            sin <= 1'b1;
          end
        end
        FRAME: begin
          if (bit_cnt != 4'd10) begin
            bit_cnt <= next_idx;
            sin     <= next_bit;
          end else if (frame_cnt != 4'd8) begin
            if (FRAME_GAP > 0) begin
              gap_cnt <= '0;
              sin     <= 1'b1;
              state   <= GAP;
            end else begin
              frame_cnt <= frame_cnt + 4'd1;
              bit_cnt   <= '0;
              sin       <= 1'b0;
            end
          end else begin
            if (PKT_GAP > 0) begin
              gap_cnt <= '0;
              sin     <= 1'b1;
              state   <= TAIL;
            end else begin
              sin   <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == FGAP_LAST) begin
            frame_cnt <= frame_cnt + 4'd1;
            bit_cnt   <= '0;
            sin       <= 1'b0;
            state     <= FRAME;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        TAIL: begin
          if (gap_cnt == PGAP_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          sin   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
